// File: rtl/shift_reg_nb_pkg.sv
// Shared constants for the serial/parallel shift register.
// Holds the bit-order encoding and the bit-counter width rule.
package shift_reg_nb_pkg;
  localparam int MSB_FIRST_ORDER = 1;
  localparam int LSB_FIRST_ORDER = 0;

  // The counter has to hold 0..WIDTH-1, and WIDTH as well for headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/shift_reg_nb_if.sv
// Bundle of control and data signals between the bit-level sampler/driver
// and the shift register.
interface shift_reg_nb_if import shift_reg_nb_pkg::*; #(
  parameter int WIDTH = 8
) ();
  localparam int CNT_W = cnt_width(WIDTH);

  logic             shift_en;
  logic             shift_in;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             clear;
  logic             shift_out;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] word_out;
  logic [CNT_W-1:0] bit_count;
  logic             done;

  modport master (
    output shift_en, shift_in, load, load_data, clear,
    input  shift_out, data_out, word_out, bit_count, done
  );

  modport slave (
    input  shift_en, shift_in, load, load_data, clear,
    output shift_out, data_out, word_out, bit_count, done
  );
endinterface

// File: rtl/shift_reg_nb_bit_counter.sv
// Counts shifts modulo MAX. wrap is combinational and flags the shift that
// completes a word.
module shift_reg_nb_bit_counter #(
  parameter int MAX   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + CNT_W'(1);
  end
endmodule

// File: rtl/shift_reg_nb.sv
// Parametrised serial/parallel shift register with a bit counter, a
// captured-word register and a one-cycle word-complete strobe.
module shift_reg_nb import shift_reg_nb_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic           clock,
  input  logic           reset,
  shift_reg_nb_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] word_q;
  logic             done_q;
  logic             do_shift;
  logic             wrap;

  // clear and load both outrank a shift in the same cycle.
  assign do_shift = bus.shift_en & ~bus.load & ~bus.clear;

  generate
    if (MSB_FIRST == MSB_FIRST_ORDER) begin : g_msb
      assign sreg_nxt      = {sreg[WIDTH-2:0], bus.shift_in};
      assign bus.shift_out = sreg[WIDTH-1];
    end else begin : g_lsb
      assign sreg_nxt      = {bus.shift_in, sreg[WIDTH-1:1]};
      assign bus.shift_out = sreg[0];
    end
  endgenerate

  shift_reg_nb_bit_counter #(.MAX(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (bus.clear | bus.load),
    .inc   (do_shift),
    .count (bus.bit_count),
    .wrap  (wrap)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg   <= '0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= wrap;
      if (bus.clear)
        sreg <= '0;
      else if (bus.load)
        sreg <= bus.load_data;
      else if (bus.shift_en) begin
        sreg <= sreg_nxt;
        // Capture includes the bit arriving on this edge.
        if (wrap) word_q <= sreg_nxt;
      end
    end
  end

  assign bus.data_out = sreg;
  assign bus.word_out = word_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_shift_reg_nb.sv
// Bench for shift_reg_nb: an 8-bit MSB-first and a 16-bit LSB-first instance,
// table vectors plus hand-written sequences, checked through a scoreboard queue.
module tb_shift_reg_nb;
  import shift_reg_nb_pkg::*;

  logic clock = 1'b0;
  logic r8, r16;
  always #5 clock = ~clock;

  shift_reg_nb_if #(.WIDTH(8))  b8 ();
  shift_reg_nb_if #(.WIDTH(16)) b16 ();

  shift_reg_nb #(.WIDTH(8),  .MSB_FIRST(MSB_FIRST_ORDER)) dut8  (.clock(clock), .reset(r8),  .bus(b8.slave));
  shift_reg_nb #(.WIDTH(16), .MSB_FIRST(LSB_FIRST_ORDER)) dut16 (.clock(clock), .reset(r16), .bus(b16.slave));

  typedef struct {
    logic        rst, clr, ld;
    logic [15:0] ldata;
    logic        en, in;
    logic [15:0] d, w;
    int          c;
    logic        dn, so;
  } vec_t;

  typedef struct {
    logic [15:0] d, w;
    int          c;
    logic        dn, so;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t tbl[$];

  // bench model state for the hand-written 8-bit sequences
  logic [7:0] md, mw;
  int         mc;

  function automatic vec_t v(logic rst, logic clr, logic ld, logic [15:0] ldata,
                             logic en, logic in, logic [15:0] d, logic [15:0] w,
                             int c, logic dn, logic so);
    vec_t r;
    r.rst = rst; r.clr = clr; r.ld = ld; r.ldata = ldata; r.en = en; r.in = in;
    r.d = d; r.w = w; r.c = c; r.dn = dn; r.so = so;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the selected instance, queue the expectation, then
  // compare one cycle later against the popped entry.
  task automatic drive(int sel, vec_t t);
    exp_t e, g;
    if (sel == 0) begin
      r8 = t.rst; b8.clear = t.clr; b8.load = t.ld; b8.load_data = t.ldata[7:0];
      b8.shift_en = t.en; b8.shift_in = t.in;
    end else begin
      r16 = t.rst; b16.clear = t.clr; b16.load = t.ld; b16.load_data = t.ldata;
      b16.shift_en = t.en; b16.shift_in = t.in;
    end
    e.d = t.d; e.w = t.w; e.c = t.c; e.dn = t.dn; e.so = t.so;
    sb.push_back(e);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    if (sel == 0) begin
      chk("data8",  {24'h0, b8.data_out},  {16'h0, g.d});
      chk("word8",  {24'h0, b8.word_out},  {16'h0, g.w});
      chk("cnt8",   {28'h0, b8.bit_count}, g.c);
      chk("done8",  {31'h0, b8.done},      {31'h0, g.dn});
      chk("sout8",  {31'h0, b8.shift_out}, {31'h0, g.so});
    end else begin
      chk("data16", {16'h0, b16.data_out},  {16'h0, g.d});
      chk("word16", {16'h0, b16.word_out},  {16'h0, g.w});
      chk("cnt16",  {27'h0, b16.bit_count}, g.c);
      chk("done16", {31'h0, b16.done},      {31'h0, g.dn});
      chk("sout16", {31'h0, b16.shift_out}, {31'h0, g.so});
    end
  endtask

  // One MSB-first shift on the 8-bit instance, expectation from the bench model.
  task automatic shift8(logic b);
    logic dn;
    md = {md[6:0], b};
    dn = 1'b0;
    if (mc == 7) begin mc = 0; mw = md; dn = 1'b1; end
    else mc++;
    drive(0, v(0, 0, 0, 16'h0, 1, b, {8'h0, md}, {8'h0, mw}, mc, dn, md[7]));
  endtask

  initial begin
    vec_t        t;
    logic [23:0] pat;
    logic [15:0] beef, ed;
    int          pulses;
    int          pulse_at[$];

    r8 = 1'b1; r16 = 1'b1;
    b8.shift_en = 0;  b8.shift_in = 0;  b8.load = 0;  b8.load_data = '0;  b8.clear = 0;
    b16.shift_en = 0; b16.shift_in = 0; b16.load = 0; b16.load_data = '0; b16.clear = 0;

    // reset with random inputs
    tbl.push_back(v(1,0,0,16'h0,0,0, 16'h00,16'h00,0,0,0));
    tbl.push_back(v(1,0,0,16'h0,0,0, 16'h00,16'h00,0,0,0));
    // receive 0xA5 MSB-first
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h01,16'h00,1,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h02,16'h00,2,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h05,16'h00,3,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h0A,16'h00,4,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h14,16'h00,5,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h29,16'h00,6,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h52,16'h00,7,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'hA5,16'hA5,0,1,1));
    tbl.push_back(v(0,0,0,16'h0,0,0, 16'hA5,16'hA5,0,0,1));
    // five 1-bits then clear (shift_en also high): aborted, word holds
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h4B,16'hA5,1,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h97,16'hA5,2,0,1));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h2F,16'hA5,3,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'h5F,16'hA5,4,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,1, 16'hBF,16'hA5,5,0,1));
    tbl.push_back(v(0,1,0,16'h0,1,1, 16'h00,16'hA5,0,0,0));
    // load 0x3C with a dropped shift, then transmit with shift_in=0
    tbl.push_back(v(0,0,1,16'h3C,1,1, 16'h3C,16'hA5,0,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h78,16'hA5,1,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'hF0,16'hA5,2,0,1));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'hE0,16'hA5,3,0,1));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'hC0,16'hA5,4,0,1));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h80,16'hA5,5,0,1));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h00,16'hA5,6,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h00,16'hA5,7,0,0));
    tbl.push_back(v(0,0,0,16'h0,1,0, 16'h00,16'h00,0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      if (t.rst) begin
        t.clr = 1'($urandom); t.ld = 1'($urandom); t.ldata = 16'($urandom);
        t.en = 1'($urandom);  t.in = 1'($urandom);
      end
      drive(0, t);
    end

    // back-to-back: 24 continuous shifts -> words 0x12, 0x34, 0x56
    md = 8'h00; mw = 8'h00; mc = 0;
    pat = 24'h123456;
    pulses = 0;
    for (int k = 1; k <= 24; k++) begin
      shift8(pat[24-k]);
      if (b8.done) begin pulses++; pulse_at.push_back(k); end
    end
    chk("b2b_pulses", pulses, 3);
    if (pulses == 3) begin
      chk("b2b_edge1", pulse_at[0], 8);
      chk("b2b_edge2", pulse_at[1], 16);
      chk("b2b_edge3", pulse_at[2], 24);
    end
    chk("b2b_word", {24'h0, b8.word_out}, 32'h56);

    // five 1-bits then reset with shift_en held: word drops to 0
    for (int k = 0; k < 5; k++) shift8(1'b1);
    drive(0, v(1,0,0,16'h0,1,1, 16'h00,16'h00,0,0,0));
    drive(0, v(1,0,0,16'h0,1,1, 16'h00,16'h00,0,0,0));
    // first shift lands on the first edge with reset low
    drive(0, v(0,0,0,16'h0,1,1, 16'h01,16'h00,1,0,0));

    // 16-bit LSB-first: 0xBEEF
    beef = 16'hBEEF;
    drive(1, v(1,0,0,16'h0,0,0, 16'h0,16'h0,0,0,0));
    for (int k = 1; k <= 16; k++) begin
      ed = 16'((32'(beef) & ((32'h1 << k) - 1)) << (16 - k));
      drive(1, v(0,0,0,16'h0,1,beef[k-1], ed, (k == 16) ? beef : 16'h0,
                 k % 16, (k == 16), ed[0]));
    end
    drive(1, v(0,0,0,16'h0,0,0, beef, beef, 0, 0, beef[0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shift_reg_nb.md
# shift_reg_nb

Parametrised serial/parallel shift register for the I2C responder datapath: the generalised next generation of the fixed 8-bit shift register. Adds configurable width and bit order, synchronous reset, a shift enable, parallel load for transmit, a bit counter, and a captured-word register with a one-cycle completion strobe. It sits between the SDA bit sampler/driver and the byte-level responder control.

## Interface
- WIDTH, 8, register width in bits (>= 2)
- MSB_FIRST, 1, 1 = shift toward MSB (I2C order), 0 = shift toward LSB
- CNT_W, $clog2(WIDTH+1), bit counter width (localparam, not overridable)

- clock  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- shift_en  in  1  qualifies one shift this cycle
- shift_in  in  1  serial bit entering the register
- load  in  1  parallel load of load_data
- load_data  in  WIDTH  word for parallel load (transmit)
- clear  in  1  synchronous clear of the register and counter (e.g. on START/STOP)
- shift_out  out  1  bit that leaves on the next shift; MSB if MSB_FIRST, else LSB
- data_out  out  WIDTH  live register contents
- word_out  out  WIDTH  last completed word
- bit_count  out  CNT_W  shifts since last load/clear/wrap, 0..WIDTH-1
- done  out  1  one-cycle strobe: WIDTH shifts completed

## Operation
- Priority per cycle: reset > clear > load > shift_en > hold.
- reset: register, word_out, bit_count and done go to 0.
- clear: register and bit_count go to 0, done goes to 0; word_out holds.
- load: register <= load_data, bit_count <= 0, done <= 0. A shift_en asserted in the same cycle is dropped.
- shift_en with MSB_FIRST=1: reg <= {reg[WIDTH-2:0], shift_in}. With MSB_FIRST=0: reg <= {shift_in, reg[WIDTH-1:1]}.
- On each shift, bit_count increments. When bit_count = WIDTH-1 and a shift occurs:
  - bit_count wraps to 0.
  - word_out <= the new register value, including the incoming bit.
  - done <= 1.
- done is 0 in every other cycle. Back-to-back words produce one done pulse per WIDTH shifts with no gap.
- Hold, i.e. no control asserted: all state holds and done <= 0.
- shift_out is combinational from the register, so it is valid in the same cycle as a load result. It is not taken from shift_in.

## Timing
- All state updates on the rising edge of clock. Outputs are registered, except shift_out, which is a pure select of register bits.
- Latency: shift_in appears in data_out one cycle after the qualifying edge. For WIDTH=8 and MSB_FIRST=1, a bit shifted in reaches shift_out after 7 further shifts.
- done asserts in the cycle after the WIDTH-th shift edge, together with the updated word_out and data_out.
- Reset asserted mid-word aborts the word: no done, and word_out = 0.
- clear mid-word aborts the word: no done, and word_out holds its previous value.
- shift_en held across reset deassertion: the first shift occurs on the first edge with reset low.

## Structure
- Single module.
- The bit counter and wrap/done logic may be factored into a sub-module bit_counter with parameters MAX=WIDTH and width CNT_W, ports clock/reset/clear/inc/count/wrap. That split is natural but optional.
- Shared package/include holds only the CNT_W derivation ($clog2(WIDTH+1)) and the MSB_FIRST encoding constants. No typedefs are needed.

## Test plan
- Reset: WIDTH=8, assert reset 2 cycles with random inputs -> data_out=0x00, word_out=0x00, bit_count=0, done=0, shift_out=0.
- Receive, MSB_FIRST=1: shift in 1,0,1,0,0,1,0,1 on consecutive cycles -> done high for exactly one cycle after the 8th edge, word_out=0xA5, data_out=0xA5, bit_count=0.
- Transmit: load 0x3C, then 8 shifts with shift_in=0 -> shift_out sequence 0,0,1,1,1,1,0,0. load with shift_en in the same cycle -> data_out=0x3C, bit_count=0.
- LSB-first, WIDTH=16, MSB_FIRST=0: shift in 0xBEEF LSB-first -> word_out=0xBEEF and one done pulse.
- Abort: after 5 shifts of 0xFF bits, assert clear -> bit_count=0, data_out=0, word_out keeps the prior 0xA5, no done. The same sequence with reset instead -> word_out=0.
- Back-to-back: 24 continuous shifts at WIDTH=8 -> done at shift edges 8, 16 and 24 exactly, with word_out updated each time.
